// File: rtl/seg7_num_display.sv
// seg7_num_display
//   Multi-digit 7-segment driver. Captures a binary value and shows it on
//   NUM_DIGITS active-low displays as hex or decimal. Decimal digits come
//   from a serial double-dabble conversion taking DATA_W cycles. Values that
//   do not fit in NUM_DIGITS digits are shown as dashes on every digit.
//
//   Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     value_in     DATA_W-bit unsigned value
//     value_valid  capture strobe, honoured only while not busy
//     dec_mode     1 = decimal, 0 = hex; captured with value_in
//     busy         capture in progress
//     seg_out      active-low segments, digit k at [8k+7:8k], bit 7 = DP
//     seg_valid    one-cycle pulse when seg_out is written

module seg7_digit_enc (
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       dash,
   output logic [7:0] seg
);
   logic [6:0] pat;

   always_comb begin
      pat = 7'h00;
      case (nib)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         default: pat = 7'h71;
      endcase
   end

   // Dash has priority over blanking; DP stays off (high) in every case.
   assign seg = dash  ? 8'hBF :
                blank ? 8'hFF : {1'b1, ~pat};
endmodule

module seg7_num_display #(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       value_in,
   input  logic                    value_valid,
   input  logic                    dec_mode,
   output logic                    busy,
   output logic [8*NUM_DIGITS-1:0] seg_out,
   output logic                    seg_valid
);
   localparam int BCD_W = 4*NUM_DIGITS;
   localparam int HW    = (DATA_W > BCD_W) ? DATA_W : BCD_W;
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  val_q;
   logic               dec_q;
   logic [BCD_W-1:0]   bcd_q, bcd_adj;
   logic               ovf_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [HW-1:0]                 val_ext;
   logic                          hex_ovf, dash;
   logic [NUM_DIGITS-1:0][3:0]    nib;
   logic [NUM_DIGITS-1:0]         blank;
   logic [8*NUM_DIGITS-1:0]       enc;

   // ---------------- state register / next state ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (value_valid) state_d = dec_mode ? SHIFT : ENCODE;
         SHIFT:   if (cnt_q == CNT_W'(DATA_W-1)) state_d = ENCODE;
         ENCODE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- double-dabble correction ----------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
   end

   // ---------------- datapath / outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q     <= '0;
         dec_q     <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         seg_out   <= '1;
         seg_valid <= 1'b0;
      end else begin
         seg_valid <= 1'b0;
         case (state_q)
            IDLE: if (value_valid) begin
               val_q <= value_in;
               dec_q <= dec_mode;
               bcd_q <= '0;
               ovf_q <= 1'b0;
               cnt_q <= '0;
               busy  <= 1'b1;
            end
            SHIFT: begin
               // MSB of the value enters the BCD LSB; a carry out of the
               // top nibble means the number needs more digits than we have.
               bcd_q <= {bcd_adj[BCD_W-2:0], val_q[DATA_W-1]};
               val_q <= val_q << 1;
               ovf_q <= ovf_q | bcd_adj[BCD_W-1];
               cnt_q <= cnt_q + CNT_W'(1);
            end
            ENCODE: begin
               seg_out   <= enc;
               seg_valid <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- encode ----------------
   assign val_ext = HW'(val_q);

   generate
      if (HW > BCD_W) begin : g_hex_ovf
         assign hex_ovf = |val_ext[HW-1:BCD_W];
      end else begin : g_no_hex_ovf
         assign hex_ovf = 1'b0;
      end
   endgenerate

   assign dash = dec_q ? ovf_q : hex_ovf;

   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++)
         nib[k] = dec_q ? bcd_q[4*k +: 4] : val_ext[4*k +: 4];
   end

   always_comb begin
      blank = '0;
`ifdef SEG7_LZB_EN
      begin : lzb
         logic lead;
         lead = 1'b1;
         // Walk down from the top digit; digit 0 is never blanked.
         for (int k = NUM_DIGITS-1; k > 0; k--) begin
            if (nib[k] != 4'd0) lead = 1'b0;
            blank[k] = lead;
         end
      end
`endif
   end

   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
         seg7_digit_enc u_enc (
            .nib   (nib[g]),
            .blank (blank[g]),
            .dash  (dash),
            .seg   (enc[8*g +: 8])
         );
      end
   endgenerate
endmodule

// File: tb/tb_seg7_num_display.sv
module tb_seg7_num_display;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] val = '0;
   logic        valid = 1'b0;
   logic        dec = 1'b0;

   logic        busy_a, busy_b, busy_c;
   logic        sv_a, sv_b, sv_c;
   logic [31:0] seg_a, seg_c;
   logic [39:0] seg_b;

`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   always #5 clk = ~clk;

   seg7_num_display #(.DATA_W(16), .NUM_DIGITS(4)) dut_a (
      .clk(clk), .rst(rst), .value_in(val[15:0]), .value_valid(valid), .dec_mode(dec),
      .busy(busy_a), .seg_out(seg_a), .seg_valid(sv_a));
   seg7_num_display #(.DATA_W(20), .NUM_DIGITS(5)) dut_b (
      .clk(clk), .rst(rst), .value_in(val), .value_valid(valid), .dec_mode(dec),
      .busy(busy_b), .seg_out(seg_b), .seg_valid(sv_b));
   seg7_num_display #(.DATA_W(20), .NUM_DIGITS(4)) dut_c (
      .clk(clk), .rst(rst), .value_in(val), .value_valid(valid), .dec_mode(dec),
      .busy(busy_c), .seg_out(seg_c), .seg_valid(sv_c));

   int dw [3] = '{16, 20, 20};
   int nd [3] = '{4, 5, 4};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int e0    = 0;
   int nv [3];
   int vc [3];
   int bc [3];
   logic [39:0] so [3];
   logic [39:0] last [3];
   logic sb [3];
   logic sv [3];

   always_comb begin
      so[0] = {8'h00, seg_a}; so[1] = seg_b; so[2] = {8'h00, seg_c};
      sb[0] = busy_a; sb[1] = busy_b; sb[2] = busy_c;
      sv[0] = sv_a;   sv[1] = sv_b;   sv[2] = sv_c;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (sv[i]) begin last[i] = so[i]; nv[i]++; vc[i] = cyc; end
         if (sb[i]) bc[i]++;
      end
   end

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
         12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   // Reference: digits by plain division, overflow by magnitude comparison.
   function automatic logic [39:0] model(input logic [19:0] v, input bit d, input int w, input int n);
      longint unsigned x, base, lim, dv;
      logic [39:0] r;
      bit ovf, lead;
      int dig;
      x = longint'(v) & ((64'd1 << w) - 1);
      base = d ? 10 : 16;
      lim = 1;
      for (int i = 0; i < n; i++) lim *= base;
      ovf = (x >= lim);
      r = '0;
      lead = 1'b1;
      for (int k = n-1; k >= 0; k--) begin
         dv = 1;
         for (int i = 0; i < k; i++) dv *= base;
         dig = int'((x / dv) % base);
         if (dig != 0) lead = 1'b0;
         if (ovf)                        r[8*k +: 8] = 8'hBF;
         else if (LZB && lead && k != 0) r[8*k +: 8] = 8'hFF;
         else                            r[8*k +: 8] = {1'b1, ~pat(dig)};
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic clr_mon();
      for (int i = 0; i < 3; i++) begin nv[i] = 0; bc[i] = 0; vc[i] = -1; end
   endtask

   // Pulse value_valid for one edge (E0); returns with e0 = cycle count after E0.
   task automatic start(input logic [19:0] v, input bit d);
      clr_mon();
      val = v; dec = d; valid = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      for (t = 0; t < 60; t++) begin
         if (!busy_a && !busy_b && !busy_c && nv[0] != 0 && nv[1] != 0 && nv[2] != 0) break;
         @(posedge clk); #1;
      end
      if (t == 60) chk("timeout", 64'(t), 64'd0);
   endtask

   task automatic chk_dut(input int i, input logic [19:0] v, input bit d, input string tag);
      chk($sformatf("%s seg[%0d] v=%h d=%0d", tag, i, v, d), 64'(last[i]), 64'(model(v, d, dw[i], nd[i])));
      chk($sformatf("%s latency[%0d]", tag, i), 64'(vc[i] - e0), 64'(d ? dw[i] + 1 : 1));
      chk($sformatf("%s pulses[%0d]", tag, i), 64'(nv[i]), 64'd1);
      chk($sformatf("%s busy_cycles[%0d]", tag, i), 64'(bc[i]), 64'(d ? dw[i] + 1 : 1));
   endtask

   typedef struct {
      logic [19:0] v;
      bit          d;
      int          which;
      logic [39:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{20'h012AF, 1'b0, 0, 40'hF9A4_888E};
      vecs[1] = '{20'd1234,  1'b1, 0, 40'hF9A4_B099};
      vecs[2] = '{20'd12345, 1'b1, 0, 40'hBFBF_BFBF};
      vecs[3] = '{20'd12345, 1'b1, 1, 40'hF9_A4B0_9992};
      vecs[4] = '{20'h10000, 1'b0, 2, 40'hBFBF_BFBF};
      vecs[5] = '{20'd7,     1'b1, 0, LZB ? 40'hFFFF_FFF8 : 40'hC0C0_C0F8};
      vecs[6] = '{20'h00000, 1'b0, 0, LZB ? 40'hFFFF_FFC0 : 40'hC0C0_C0C0};
      vecs[7] = '{20'h0FFFF, 1'b0, 0, 40'h8E8E_8E8E};
      vecs[8] = '{20'd9999,  1'b1, 0, 40'h9090_9090};
      vecs[9] = '{20'd10000, 1'b1, 0, 40'hBFBF_BFBF};

      clr_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("reset seg_a", 64'(seg_a), 64'hFFFF_FFFF);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-reset seg_a", 64'(seg_a), 64'hFFFF_FFFF);
      chk("post-reset seg_b", 64'(seg_b), 64'hFF_FFFF_FFFF);
      chk("post-reset busy", 64'({busy_a, busy_b, busy_c}), 64'd0);
      chk("post-reset seg_valid", 64'({sv_a, sv_b, sv_c}), 64'd0);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         start(vecs[i].v, vecs[i].d);
         wait_done();
         chk($sformatf("vec%0d seg", i), 64'(last[vecs[i].which]), 64'(vecs[i].exp));
         chk($sformatf("vec%0d latency", i), 64'(vc[vecs[i].which] - e0),
             64'(vecs[i].d ? dw[vecs[i].which] + 1 : 1));
         chk($sformatf("vec%0d pulses", i), 64'(nv[vecs[i].which]), 64'd1);
         if (vecs[i].which == 0)
            chk($sformatf("vec%0d hold seg_out", i), 64'(seg_a), 64'(vecs[i].exp));
         @(posedge clk); #1;
      end

      // Request during SHIFT is dropped
      start(20'd99, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      val = 20'd55; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      wait_done();
      for (int i = 0; i < 3; i++) chk_dut(i, 20'd99, 1'b1, "drop");
      repeat (3) @(posedge clk);
      #1;
      chk("drop no extra pulse", 64'(nv[0] + nv[1] + nv[2]), 64'd3);

      // Reset mid-conversion
      start(20'd1234, 1'b1);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #2;
      chk("abort busy", 64'({busy_a, busy_b, busy_c}), 64'd0);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("abort pulses", 64'(nv[0] + nv[1] + nv[2]), 64'd0);
      chk("abort seg_a", 64'(seg_a), 64'hFFFF_FFFF);
      chk("abort seg_b", 64'(seg_b), 64'hFF_FFFF_FFFF);
      chk("abort busy later", 64'({busy_a, busy_b, busy_c}), 64'd0);

      // Random values against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [19:0] rv;
         bit rd;
         rv = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(0, 20000)) : 20'($urandom);
         rd = 1'($urandom_range(0, 1));
         start(rv, rd);
         wait_done();
         for (int i = 0; i < 3; i++) chk_dut(i, rv, rd, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_num_display.md
# seg7_num_display

Parametrised multi-digit 7-segment display driver for the DE10-Lite HEX displays. It accepts a binary value with a valid strobe and converts it to hexadecimal or decimal digits. Decimal conversion uses an iterative double-dabble state machine. It then registers active-low segment patterns for `NUM_DIGITS` displays. It sits between arithmetic result producers (multiplier, counters) and the board's HEX pins.

## Interface
Parameters:
- `DATA_W`, 16, width of the binary input value (≥ 4).
- `NUM_DIGITS`, 4, number of 7-segment digits driven (1–8).

Ports:
- `clk`  input  1  single system clock; all state on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `value_in`  input  DATA_W  unsigned binary value to display.
- `value_valid`  input  1  capture strobe; sampled only when not busy.
- `dec_mode`  input  1  1 = decimal display, 0 = hexadecimal; sampled with `value_in`.
- `busy`  output  1  high while a capture is being converted.
- `seg_out`  output  8*NUM_DIGITS  active-low segments; digit k at bits [8k+7:8k], digit 0 least significant; bit 7 = DP, bits 6:0 = g..a.
- `seg_valid`  output  1  one-cycle pulse when `seg_out` updates.

## Operation
- States: IDLE, SHIFT, ENCODE.
- **IDLE:**
  - On an edge with `value_valid`=1, latch `value_in` and `dec_mode`.
  - Clear the BCD register and the overflow flag, and set `busy`.
  - Go to SHIFT if `dec_mode`=1, else to ENCODE.
- **SHIFT:**
  - Runs exactly DATA_W cycles, MSB first.
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift the BCD register (4*NUM_DIGITS bits) left, shifting in the next value bit.
  - A 1 shifted out of the BCD MSB sets sticky overflow.
  - After the last shift, go to ENCODE.
- **ENCODE:**
  - Source nibbles are the BCD nibbles in decimal mode, or value nibbles in hex mode (zero-extended if DATA_W < 4*NUM_DIGITS).
  - Hex overflow: any value bit at or above index 4*NUM_DIGITS is nonzero.
  - Write `seg_out`, pulse `seg_valid`, clear `busy`, go to IDLE.
- Active-high segment patterns, before inversion: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. The DP is always off (output bit 7 = 1).
- Overflow: every digit shows a dash, 8'hBF.
- `value_valid` while `busy`=1 is ignored and the request is dropped, with no queueing.
- `seg_out` holds its last value between updates.

## Timing
- Reset values: `seg_out` all ones (blank), `busy`=0, `seg_valid`=0, state IDLE, internal registers 0.
- Reset asserted mid-conversion aborts the conversion: no `seg_valid`, and `seg_out` is blanked.
- Capture edge E0: `busy`=1 after E0.
- Hex mode latency: `seg_out`/`seg_valid` update at E1.
- Decimal mode latency: update at E(DATA_W+1). `busy` is high for DATA_W+1 cycles.
- `busy` falls at the same edge `seg_valid` rises. A new `value_valid` is accepted on the following edge at the earliest.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking is enabled.
  - Zero digits above the most significant nonzero digit show 8'hFF.
  - Digit 0 is always displayed.
  - Overflow dashes are unaffected.
- `SEG7_LZB_EN` undefined: all digits are displayed, including leading zeros.

## Test plan
- Reset with `rst`=1 then release, defaults → `seg_out`=32'hFFFF_FFFF, `busy`=0, `seg_valid`=0.
- Hex, value 16'h12AF, `dec_mode`=0 → at E1, `seg_out`=32'hF9A4_888E, `seg_valid` high for exactly 1 cycle.
- Decimal, value 16'd1234 → `busy` high 17 cycles; at E17, `seg_out`=32'hF9A4_B099.
- Overflow cases:
  - Decimal, 16'd12345 with NUM_DIGITS=4 → 32'hBFBF_BFBF.
  - Same value with NUM_DIGITS=5 → 40'hF9_A4B0_9992.
  - Hex, DATA_W=20, value 20'h10000 → 32'hBFBF_BFBF.
- Decimal, value 16'd7 → with `SEG7_LZB_EN`: 32'hFFFF_FFF8; without: 32'hC0C0_C0F8.
- Decimal, 16'd99, then `value_valid` with 16'd55 pulsed during SHIFT → the 16'd55 request is ignored and the result shows 99.
- Decimal, `rst` pulsed at cycle 8 of SHIFT → no `seg_valid`, `seg_out` all ones, `busy`=0.
